// File: rtl/parity_steer_router_if.sv
// parity_steer_router_if: request/response bus of the parity-steered router
interface parity_steer_router_if #(
   parameter int SEL_W  = 2,
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
);
   localparam int N = 1 << SEL_W;
   logic              in_valid;
   logic              in_ready;
   logic [N-1:0]      in_bits;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] data;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      out_bits;
   logic [SEL_W-1:0]  out_dest;
   logic [CNT_W-1:0]  inv_cnt;
   logic              cnt_clr;
   modport slave (
      input  in_valid, in_bits, sel, data, out_ready, cnt_clr,
      output in_ready, out_valid, out_bits, out_dest, inv_cnt
   );
   modport master (
      output in_valid, in_bits, sel, data, out_ready, cnt_clr,
      input  in_ready, out_valid, out_bits, out_dest, inv_cnt
   );
endinterface

// File: rtl/parity_steer_router.sv
// parity_steer_router: two-stage parity-steered bit router with inversion counter
module parity_steer_router #(
   parameter int SEL_W  = 2,
   parameter int DATA_W = 4,
   parameter bit INV_ON = 1'b0,
   parameter int CNT_W  = 8
) (
   input  logic clk,
   input  logic rst_n,
   parity_steer_router_if.slave bus
);
   localparam int N = 1 << SEL_W;
   typedef enum logic [1:0] {EMPTY = 2'b00, S2 = 2'b01, S1 = 2'b10, FULL = 2'b11} state_t;
   state_t            state_q, state_d;
   logic              b1_q;
   logic [SEL_W-1:0]  d1_q, dest_q;
   logic [N-1:0]      bits_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] data_w;
   logic              s1_v, s2_v, accept, adv, inv1;
   assign s1_v          = state_q[1];
   assign s2_v          = state_q[0];
   assign data_w        = bus.data;
   assign inv1          = (^data_w) == INV_ON;
   assign adv           = s1_v && (!s2_v || bus.out_ready);
   assign bus.in_ready  = !s1_v || !s2_v || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = s2_v;
   assign bus.out_bits  = bits_q;
   assign bus.out_dest  = dest_q;
   assign bus.inv_cnt   = cnt_q;
   // occupancy state: state encoding is {s1_v, s2_v}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end
   // S1 fills on accept or keeps its item when it cannot advance; S2 fills on advance or holds while stalled
   always_comb begin
      state_d = state_q;
      state_d = state_t'({accept || (s1_v && !adv), adv || (s2_v && !bus.out_ready)});
   end
   // pipeline data: S1 samples the request, S2 places the bit at its destination channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b1_q   <= 1'b0;
         d1_q   <= '0;
         dest_q <= '0;
         bits_q <= '0;
      end else begin
         if (accept) begin
            b1_q <= bus.in_bits[bus.sel];
            d1_q <= inv1 ? ~bus.sel : bus.sel;
         end
         if (adv) begin
            dest_q <= d1_q;
            bits_q <= {{(N-1){1'b0}}, b1_q} << d1_q;
         end
      end
   end
   // saturating count of accepted inverted routings; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                cnt_q <= '0;
      else if (bus.cnt_clr)                      cnt_q <= '0;
      else if (accept && inv1 && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: tb/tb_parity_steer_router.sv
// tb_parity_steer_router: directed self-checking bench for parity_steer_router
`timescale 1ns/1ps
module tb_parity_steer_router;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;

   parity_steer_router_if #(.SEL_W(2), .DATA_W(4), .CNT_W(8)) bus ();
   parity_steer_router_if #(.SEL_W(2), .DATA_W(4), .CNT_W(2)) bus2 ();

   parity_steer_router #(.SEL_W(2), .DATA_W(4), .INV_ON(1'b0), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   parity_steer_router #(.SEL_W(2), .DATA_W(4), .INV_ON(1'b0), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(bus2));

   // stream vectors with hand-computed destinations and placed bits
   logic [3:0] s_bits [8] = '{4'b0001, 4'b0010, 4'b1111, 4'b0000, 4'b0100, 4'b1000, 4'b1011, 4'b0010};
   logic [1:0] s_sel  [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1};
   logic [3:0] s_data [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0001, 4'b1000, 4'b1111, 4'b0110, 4'b1010};
   logic [1:0] s_dest [8] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2};
   logic [3:0] s_out  [8] = '{4'b1000, 4'b0010, 4'b0001, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0100};
   // backpressure offers A, B, C (C must never be accepted)
   logic [3:0] b_bits [3] = '{4'b0001, 4'b1000, 4'b0100};
   logic [1:0] b_sel  [3] = '{2'd0, 2'd3, 2'd2};
   logic [3:0] b_data [3] = '{4'b0001, 4'b0001, 4'b0011};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] b, input logic [1:0] s, input logic [3:0] d);
      bus.in_valid = v;
      bus.in_bits  = b;
      bus.sel      = s;
      bus.data     = d;
   endtask

   initial begin
      int  o;
      logic acc;
      drive(1'b0, 4'b0, 2'd0, 4'b0);
      bus.out_ready  = 1'b1;
      bus.cnt_clr    = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_bits   = 4'b0;
      bus2.sel       = 2'd0;
      bus2.data      = 4'b0;
      bus2.out_ready = 1'b1;
      bus2.cnt_clr   = 1'b0;
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_inv_cnt", 32'(bus.inv_cnt), 32'd0);
      check("rst_out_bits", 32'(bus.out_bits), 32'd0);
      rst_n = 1'b1;
      step;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // even parity request is inverted: sel 2 -> dest 1
      drive(1'b1, 4'b0100, 2'd2, 4'b0011);
      step;
      bus.in_valid = 1'b0;
      check("inv_s1_only", 32'(bus.out_valid), 32'd0);
      step;
      check("inv_valid", 32'(bus.out_valid), 32'd1);
      check("inv_dest", 32'(bus.out_dest), 32'd1);
      check("inv_bits", 32'(bus.out_bits), 32'b0010);
      check("inv_cnt1", 32'(bus.inv_cnt), 32'd1);

      // odd parity request keeps sel 2
      drive(1'b1, 4'b0100, 2'd2, 4'b0111);
      step;
      bus.in_valid = 1'b0;
      step;
      check("str_valid", 32'(bus.out_valid), 32'd1);
      check("str_dest", 32'(bus.out_dest), 32'd2);
      check("str_bits", 32'(bus.out_bits), 32'b0100);
      check("str_cnt", 32'(bus.inv_cnt), 32'd1);
      step;
      check("str_drained", 32'(bus.out_valid), 32'd0);

      // back-to-back stream of 8 requests
      for (int t = 0; t < 10; t++) begin
         if (t < 8) drive(1'b1, s_bits[t], s_sel[t], s_data[t]);
         else bus.in_valid = 1'b0;
         check($sformatf("stream_in_ready%0d", t), 32'(bus.in_ready), 32'd1);
         check($sformatf("stream_valid%0d", t), 32'(bus.out_valid), (t >= 2) ? 32'd1 : 32'd0);
         if (t >= 2) begin
            check($sformatf("stream_dest%0d", t - 2), 32'(bus.out_dest), 32'(s_dest[t-2]));
            check($sformatf("stream_bits%0d", t - 2), 32'(bus.out_bits), 32'(s_out[t-2]));
         end
         step;
      end
      check("stream_end_valid", 32'(bus.out_valid), 32'd0);
      check("stream_cnt", 32'(bus.inv_cnt), 32'd6);

      // backpressure: three offers, only two fit
      bus.out_ready = 1'b0;
      o = 0;
      for (int c = 0; c < 5; c++) begin
         if (o < 3) drive(1'b1, b_bits[o], b_sel[o], b_data[o]);
         else bus.in_valid = 1'b0;
         if (c >= 2) begin
            check($sformatf("bp_in_ready%0d", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp_valid%0d", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_dest%0d", c), 32'(bus.out_dest), 32'd0);
            check($sformatf("bp_bits%0d", c), 32'(bus.out_bits), 32'b0001);
         end
         acc = bus.in_ready;
         step;
         if (acc && o < 3) o++;
      end
      check("bp_accepted", 32'(o), 32'd2);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_drain_a_dest", 32'(bus.out_dest), 32'd0);
      check("bp_drain_a_bits", 32'(bus.out_bits), 32'b0001);
      step;
      check("bp_drain_b_valid", 32'(bus.out_valid), 32'd1);
      check("bp_drain_b_dest", 32'(bus.out_dest), 32'd3);
      check("bp_drain_b_bits", 32'(bus.out_bits), 32'b1000);
      step;
      check("bp_empty", 32'(bus.out_valid), 32'd0);
      check("bp_cnt", 32'(bus.inv_cnt), 32'd6);

      // 2-bit counter saturates, then clear beats a same-cycle increment
      bus2.in_valid = 1'b1;
      bus2.in_bits  = 4'b0001;
      bus2.sel      = 2'd0;
      bus2.data     = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         step;
         check($sformatf("sat_cnt%0d", i), 32'(bus2.inv_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      bus2.cnt_clr = 1'b1;
      step;
      check("sat_clr", 32'(bus2.inv_cnt), 32'd0);
      bus2.cnt_clr  = 1'b0;
      bus2.in_valid = 1'b0;
      step;
      check("sat_after_clr", 32'(bus2.inv_cnt), 32'd0);

      // asynchronous reset with two items stalled
      bus.out_ready = 1'b0;
      drive(1'b1, 4'b0001, 2'd0, 4'b0000);
      step;
      drive(1'b1, 4'b0010, 2'd1, 4'b0000);
      step;
      bus.in_valid = 1'b0;
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_valid", 32'(bus.out_valid), 32'd1);
      check("full_cnt", 32'(bus.inv_cnt), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_cnt", 32'(bus.inv_cnt), 32'd0);
      check("arst_bits", 32'(bus.out_bits), 32'd0);
      check("arst_dest", 32'(bus.out_dest), 32'd0);
      #3 rst_n = 1'b1;
      #1;
      check("arst_in_ready", 32'(bus.in_ready), 32'd1);
      step;
      check("arst_discarded", 32'(bus.out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
